// File: rtl/perceptron_trainer_if.sv
// Load/start/result bus of the perceptron trainer.
// The master side loads samples and starts a run; the slave side (the trainer) reports status and weights.
interface perceptron_trainer_if #(
  parameter int unsigned W          = 16,
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_SAMP     = 4,
  parameter int unsigned MAX_EPOCHS = 16
);
  localparam int unsigned IDX_W = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam int unsigned EP_W  = $clog2(MAX_EPOCHS + 1);
  localparam int unsigned ERR_W = $clog2(N_SAMP + 1);

  logic                    start;
  logic                    load_en;
  logic [IDX_W-1:0]        load_idx;
  logic [N_IN*W-1:0]       load_x;
  logic                    load_d;
  logic [W-1:0]            u;
  logic [(N_IN+1)*W-1:0]   w_init;
  logic                    busy;
  logic                    done;
  logic                    converged;
  logic [EP_W-1:0]         epoch_count;
  logic [ERR_W-1:0]        err_count;
  logic [(N_IN+1)*W-1:0]   w_out;

  modport master (
    output start, load_en, load_idx, load_x, load_d, u, w_init,
    input  busy, done, converged, epoch_count, err_count, w_out
  );

  modport slave (
    input  start, load_en, load_idx, load_x, load_d, u, w_init,
    output busy, done, converged, epoch_count, err_count, w_out
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Serial fixed-point perceptron trainer: epochs over an internal sample memory until
// an error-free epoch or the epoch limit, one input (or one weight update) per cycle.
module perceptron_trainer #(
  parameter int unsigned W          = 16,
  parameter int unsigned FRAC       = 10,
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_SAMP     = 4,
  parameter int unsigned MAX_EPOCHS = 16
) (
  input logic                clk,
  input logic                reset,
  perceptron_trainer_if.slave bus
);
  localparam int unsigned ACC_W = W + 8;
  localparam int unsigned IDX_W = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam int unsigned K_W   = $clog2(N_IN + 1);
  localparam int unsigned EP_W  = $clog2(MAX_EPOCHS + 1);
  localparam int unsigned ERR_W = $clog2(N_SAMP + 1);
  localparam logic signed [W-1:0] ONE     = W'(1 << FRAC);
  localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_EVAL, S_UPDATE, S_NEXT} state_e;

  state_e                  state_q, state_d;
  logic signed [W-1:0]     w_q [N_IN+1];
  logic signed [W-1:0]     w_d [N_IN+1];
  logic [N_IN*W-1:0]       x_mem_q [N_SAMP];
  logic [N_IN*W-1:0]       x_mem_d [N_SAMP];
  logic [N_SAMP-1:0]       d_mem_q, d_mem_d;
  logic signed [W-1:0]     u_q, u_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    e_pos_q, e_pos_d;
  logic [ERR_W-1:0]        ep_err_q, ep_err_d, err_cnt_q, err_cnt_d;
  logic [EP_W-1:0]         epoch_q, epoch_d, epoch_inc;
  logic                    conv_q, conv_d, done_q, done_d, busy_q, busy_d;

  logic [N_IN*W-1:0]       x_row;
  logic                    d_cur;
  logic signed [W-1:0]     x_k, x_up, w_k, w_k1, w_new;
  logic signed [2*W-1:0]   prod_sum, prod_upd, delta;
  logic signed [ACC_W-1:0] sum_term;
  logic signed [2*W:0]     w_ext, d_ext, upd_sum;

  // Operand selection, MAC term and saturating weight update for the current k
  always_comb begin
    x_row = '0;
    d_cur = 1'b0;
    for (int s = 0; s < int'(N_SAMP); s++) begin
      if (idx_q == IDX_W'(s)) begin
        x_row = x_mem_q[s];
        d_cur = d_mem_q[s];
      end
    end
    x_k  = '0;
    x_up = ONE;
    w_k  = '0;
    w_k1 = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (k_q == K_W'(i)) begin
        x_k  = x_row[i*W +: W];
        w_k1 = w_q[i+1];
      end
      if (k_q == K_W'(i + 1)) x_up = x_row[i*W +: W];
    end
    for (int j = 0; j <= int'(N_IN); j++) begin
      if (k_q == K_W'(j)) w_k = w_q[j];
    end
    prod_sum = (2*W)'(w_k1) * (2*W)'(x_k);
    sum_term = ACC_W'(prod_sum >>> FRAC);
    prod_upd = (2*W)'(u_q) * (2*W)'(x_up);
    delta    = prod_upd >>> FRAC;
    w_ext    = {{(W+1){w_k[W-1]}}, w_k};
    d_ext    = {delta[2*W-1], delta};
    upd_sum  = e_pos_q ? (w_ext + d_ext) : (w_ext - d_ext);
    if (upd_sum > SAT_MAX)      w_new = SAT_MAX[W-1:0];
    else if (upd_sum < SAT_MIN) w_new = SAT_MIN[W-1:0];
    else                        w_new = upd_sum[W-1:0];
  end

  assign epoch_inc = epoch_q + EP_W'(1);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    x_mem_d   = x_mem_q;
    d_mem_d   = d_mem_q;
    u_d       = u_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    k_d       = k_q;
    e_pos_d   = e_pos_q;
    ep_err_d  = ep_err_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    conv_d    = conv_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        for (int s = 0; s < int'(N_SAMP); s++) begin
          if (bus.load_en && bus.load_idx == IDX_W'(s)) begin
            x_mem_d[s] = bus.load_x;
            d_mem_d[s] = bus.load_d;
          end
        end
        if (bus.start) begin
          u_d = bus.u;
          for (int j = 0; j <= int'(N_IN); j++) w_d[j] = bus.w_init[j*W +: W];
          acc_d    = ACC_W'($signed(bus.w_init[W-1:0]));
          epoch_d  = '0;
          conv_d   = 1'b0;
          ep_err_d = '0;
          idx_d    = '0;
          k_d      = '0;
          state_d  = S_SUM;
        end
      end
      S_SUM: begin
        acc_d = acc_q + sum_term;
        if (k_q == K_W'(N_IN - 1)) begin
          k_d     = '0;
          state_d = S_EVAL;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_EVAL: begin
        // y = ~acc sign, so an error is d equal to the sign bit; e > 0 exactly when d = 1
        if (d_cur == acc_q[ACC_W-1]) begin
          e_pos_d  = d_cur;
          ep_err_d = ep_err_q + ERR_W'(1);
          k_d      = '0;
          state_d  = S_UPDATE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_UPDATE: begin
        for (int j = 0; j <= int'(N_IN); j++) begin
          if (k_q == K_W'(j)) w_d[j] = w_new;
        end
        if (k_q == K_W'(N_IN)) begin
          k_d     = '0;
          state_d = S_NEXT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_NEXT: begin
        k_d   = '0;
        acc_d = ACC_W'(w_q[0]);
        if (idx_q != IDX_W'(N_SAMP - 1)) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SUM;
        end else begin
          epoch_d   = epoch_inc;
          err_cnt_d = ep_err_q;
          if (ep_err_q == '0) begin
            conv_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (epoch_inc == EP_W'(MAX_EPOCHS)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ep_err_d = '0;
            idx_d    = '0;
            state_d  = S_SUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int j = 0; j <= int'(N_IN); j++) w_q[j] <= '0;
      for (int s = 0; s < int'(N_SAMP); s++) x_mem_q[s] <= '0;
      d_mem_q   <= '0;
      u_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      k_q       <= '0;
      e_pos_q   <= 1'b0;
      ep_err_q  <= '0;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      conv_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      x_mem_q   <= x_mem_d;
      d_mem_q   <= d_mem_d;
      u_q       <= u_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      e_pos_q   <= e_pos_d;
      ep_err_q  <= ep_err_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      conv_q    <= conv_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.converged   = conv_q;
  assign bus.epoch_count = epoch_q;
  assign bus.err_count   = err_cnt_q;

  for (genvar j = 0; j <= N_IN; j++) begin : g_wout
    assign bus.w_out[j*W +: W] = w_q[j];
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboarded bench for perceptron_trainer: each run pushes its expected result and
// a negedge monitor checks it against the done pulse, including busy-cycle counts.
module tb_perceptron_trainer;
  localparam int unsigned W = 16, FRAC = 10, N_IN = 2, N_SAMP = 4, MAX_EPOCHS = 16;
  localparam logic [15:0] ONE   = 16'h0400;
  localparam logic [15:0] U_OR  = 16'h0200;
  localparam logic [47:0] W_ONE = 48'h0400_0400_0400;
  localparam logic [47:0] W_OR  = 48'h0400_0400_FE00;
  localparam logic [47:0] W_SAT = 48'h0000_7FFF_8400;

  typedef struct {
    logic        conv;
    int          ep;
    logic        err_nz;
    int          err;
    logic        chk_w;
    logic [47:0] w;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   total, bad, busy_cnt;
  exp_t sb[$];
  exp_t cur;

  perceptron_trainer_if #(.W(W), .N_IN(N_IN), .N_SAMP(N_SAMP), .MAX_EPOCHS(MAX_EPOCHS)) bus ();

  perceptron_trainer #(
    .W(W), .FRAC(FRAC), .N_IN(N_IN), .N_SAMP(N_SAMP), .MAX_EPOCHS(MAX_EPOCHS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic conv, input int ep, input logic err_nz, input int err,
                              input logic chk_w, input logic [47:0] w, input int cyc);
    exp_t e;
    e.conv = conv; e.ep = ep; e.err_nz = err_nz; e.err = err;
    e.chk_w = chk_w; e.w = w; e.cyc = cyc;
    return e;
  endfunction

  // Monitor: count busy cycles and check each done pulse against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pulse");
        end else begin
          cur = sb.pop_front();
          chk("converged", 64'(bus.converged), 64'(cur.conv));
          chk("epoch_count", 64'(bus.epoch_count), 64'(cur.ep));
          if (cur.err_nz) begin
            total++;
            if (bus.err_count == '0) begin
              bad++;
              $display("FAIL err_count_nonzero: got 0 want nonzero");
            end
          end else begin
            chk("err_count", 64'(bus.err_count), 64'(cur.err));
          end
          if (cur.chk_w) chk("w_out", 64'(bus.w_out), 64'(cur.w));
          if (cur.cyc >= 0) chk("busy_cycles", 64'(busy_cnt), 64'(cur.cyc));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic load(input int s, input logic [15:0] x0, input logic [15:0] x1, input logic d);
    bus.load_en  = 1'b1;
    bus.load_idx = 2'(s);
    bus.load_x   = {x1, x0};
    bus.load_d   = d;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic load_gate(input logic [3:0] dv);
    load(0, 16'h0000, 16'h0000, dv[0]);
    load(1, ONE,      16'h0000, dv[1]);
    load(2, 16'h0000, ONE,      dv[2]);
    load(3, ONE,      ONE,      dv[3]);
  endtask

  task automatic start_run(input logic [15:0] u, input logic [47:0] wi);
    bus.start  = 1'b1;
    bus.u      = u;
    bus.w_init = wi;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got no done within %0d cycles want done", nm, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; busy_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.load_en = 1'b0; bus.load_idx = '0; bus.load_x = '0;
    bus.load_d = 1'b0; bus.u = '0; bus.w_init = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_converged", 64'(bus.converged), 64'd0);
    chk("rst_epoch_count", 64'(bus.epoch_count), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_w_out", 64'(bus.w_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // OR gate
    load_gate(4'b1110);
    sb.push_back(mk(1'b1, 4, 1'b0, 0, 1'b1, W_OR, 73));
    start_run(U_OR, W_ONE);
    wait_done("or", 300);

    // Back-to-back start in the done cycle from the converged weights
    sb.push_back(mk(1'b1, 1, 1'b0, 0, 1'b1, W_OR, 16));
    start_run(U_OR, W_OR);
    wait_done("b2b", 100);

    // start and load_en while busy must be ignored
    sb.push_back(mk(1'b1, 4, 1'b0, 0, 1'b1, W_OR, 73));
    start_run(U_OR, W_ONE);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.w_init = '0;
    bus.load_en = 1'b1; bus.load_idx = 2'd0; bus.load_x = '0; bus.load_d = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.load_en = 1'b0;
    wait_done("or_busy_reqs", 300);

    // Rerun: slot 0 must still hold d = 0
    sb.push_back(mk(1'b1, 4, 1'b0, 0, 1'b1, W_OR, 73));
    start_run(U_OR, W_ONE);
    wait_done("or_rerun", 300);

    // XOR never separates
    load(3, ONE, ONE, 1'b0);
    sb.push_back(mk(1'b0, 16, 1'b1, 0, 1'b0, '0, -1));
    start_run(U_OR, W_ONE);
    wait_done("xor", 1000);

    // Saturation of w[1] on the first update
    for (int s = 0; s < 4; s++) load(s, ONE, 16'h0000, 1'b1);
    sb.push_back(mk(1'b1, 2, 1'b0, 0, 1'b1, W_SAT, 35));
    start_run(16'h0400, 48'h0000_7F00_8000);
    repeat (6) @(negedge clk);
    chk("sat_first_update", 64'(bus.w_out), 64'(W_SAT));
    wait_done("sat", 300);

    // Reset during the first UPDATE cycle
    load_gate(4'b1110);
    start_run(U_OR, W_ONE);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_epoch_count", 64'(bus.epoch_count), 64'd0);
    chk("midrst_w_out", 64'(bus.w_out), 64'd0);
    chk("midrst_converged", 64'(bus.converged), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Memory cleared by reset: all x = 0, d = 0 converges in 2 epochs, 25 + 16 cycles
    sb.push_back(mk(1'b1, 2, 1'b0, 0, 1'b1, W_OR, 41));
    start_run(U_OR, W_ONE);
    wait_done("cleared_mem", 300);

    // Reload and reproduce OR
    load_gate(4'b1110);
    sb.push_back(mk(1'b1, 4, 1'b0, 0, 1'b1, W_OR, 73));
    start_run(U_OR, W_ONE);
    wait_done("or_after_reset", 300);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
